// File: rtl/c3sram_loader.sv
// c3sram_loader: request-side sequencer for the C3SRAM write/read controller.
// Takes a block command (base row, row count, direction). In write mode it
// pulls one row from the input stream per row and issues one write request
// per row. In readback mode it issues read requests and pushes the captured
// sense-amp data to the output stream.
//
// Build option: LOADER_READBACK_EN enables readback mode. Without it, mode_i
// is ignored, every block is a write, and wc_read_o/out_valid_o/out_data_o
// are tied to 0.
//
// Ports:
//   clk, nrst               clock, asynchronous active-low reset
//   start_i, mode_i         command strobe (taken only when idle), 0=write 1=read
//   base_addr_i, num_rows_i first row, row count (0..numRows)
//   in_valid_i/in_ready_o, in_data_i     write-data stream
//   out_valid_o/out_ready_i, out_data_o  readback stream
//   rd_data_i               sense-amp data, valid with wc_done_i during a read
//   wc_write_o, wc_read_o   one-cycle request pulses to the controller
//   wc_addr_o, wc_wr_data_o registered row address and write data
//   wc_ready_i, wc_done_i   controller idle flag and completion pulse
//   busy_o, finish_o        not idle; one-cycle block-complete pulse
module c3sram_loader #(
  parameter int numRows = 128,
  parameter int numCols = 32,
  localparam int AW = $clog2(numRows)
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               start_i,
  input  logic               mode_i,
  input  logic [AW-1:0]      base_addr_i,
  input  logic [AW:0]        num_rows_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [numCols-1:0] in_data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [numCols-1:0] out_data_o,
  input  logic [numCols-1:0] rd_data_i,
  output logic               wc_write_o,
  output logic               wc_read_o,
  output logic [AW-1:0]      wc_addr_o,
  output logic [numCols-1:0] wc_wr_data_o,
  input  logic               wc_ready_i,
  input  logic               wc_done_i,
  output logic               busy_o,
  output logic               finish_o
);

  localparam logic [AW-1:0] LAST_ROW = AW'(numRows - 1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [AW:0]   ROWS_ONE = (AW+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT
`ifdef LOADER_READBACK_EN
    , S_DRAIN
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [AW:0]          remaining_q, remaining_d;
  logic [numCols-1:0]   wdata_q, wdata_d;
  logic                 finish_q, finish_d;
`ifdef LOADER_READBACK_EN
  logic                 mode_q, mode_d;
  logic [numCols-1:0]   rdata_q, rdata_d;
`else
  logic                 unused_readback;
  assign unused_readback = ^{mode_i, rd_data_i, out_ready_i};
`endif

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      wdata_q     <= '0;
      finish_q    <= 1'b0;
`ifdef LOADER_READBACK_EN
      mode_q      <= 1'b0;
      rdata_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      wdata_q     <= wdata_d;
      finish_q    <= finish_d;
`ifdef LOADER_READBACK_EN
      mode_q      <= mode_d;
      rdata_q     <= rdata_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    wdata_d     = wdata_q;
    finish_d    = 1'b0;
`ifdef LOADER_READBACK_EN
    mode_d      = mode_q;
    rdata_d     = rdata_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d      = base_addr_i;
          remaining_d = num_rows_i;
`ifdef LOADER_READBACK_EN
          mode_d      = mode_i;
`endif
          // Empty block completes without leaving idle.
          if (num_rows_i == '0) begin
            finish_d = 1'b1;
          end else begin
`ifdef LOADER_READBACK_EN
            state_d = mode_i ? S_ISSUE : S_FETCH;
`else
            state_d = S_FETCH;
`endif
          end
        end
      end
      S_FETCH: begin
        if (in_valid_i) begin
          wdata_d = in_data_i;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (wc_ready_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wc_done_i) begin
          remaining_d = remaining_q - ROWS_ONE;
          addr_d      = (addr_q == LAST_ROW) ? '0 : addr_q + ADDR_ONE;
`ifdef LOADER_READBACK_EN
          if (mode_q) begin
            rdata_d = rd_data_i;
            state_d = S_DRAIN;
          end else
`endif
          if (remaining_q == ROWS_ONE) begin
            finish_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
`ifdef LOADER_READBACK_EN
      S_DRAIN: begin
        // remaining_q was already decremented when the row completed.
        if (out_ready_i) begin
          if (remaining_q != '0) begin
            state_d = S_ISSUE;
          end else begin
            finish_d = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready_o  = (state_q == S_FETCH);
    wc_write_o  = 1'b0;
    wc_read_o   = 1'b0;
    out_valid_o = 1'b0;
    out_data_o  = '0;
    if ((state_q == S_ISSUE) && wc_ready_i) begin
`ifdef LOADER_READBACK_EN
      wc_read_o  = mode_q;
      wc_write_o = !mode_q;
`else
      wc_write_o = 1'b1;
`endif
    end
`ifdef LOADER_READBACK_EN
    out_valid_o = (state_q == S_DRAIN);
    out_data_o  = rdata_q;
`endif
  end

  assign wc_addr_o    = addr_q;
  assign wc_wr_data_o = wdata_q;
  assign busy_o       = (state_q != S_IDLE);
  assign finish_o     = finish_q;

endmodule

// File: tb/tb_c3sram_loader.sv
// Testbench for c3sram_loader: directed blocks against a small 4-cycle
// controller model that logs every request it sees.
module tb_c3sram_loader;
  localparam int NR = 128;
  localparam int NC = 32;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          start_i = 1'b0;
  logic          mode_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [AW:0]   num_rows_i = '0;
  logic          in_valid_i = 1'b1;
  logic          in_ready_o;
  logic [NC-1:0] in_data_i;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [NC-1:0] out_data_o;
  logic [NC-1:0] rd_data_i = 32'hBAD0BAD0;
  logic          wc_write_o, wc_read_o;
  logic [AW-1:0] wc_addr_o;
  logic [NC-1:0] wc_wr_data_o;
  logic          wc_ready_i;
  logic          wc_done_i = 1'b0;
  logic          busy_o, finish_o;

  int checks = 0;
  int errors = 0;

  c3sram_loader #(.numRows(NR), .numCols(NC)) dut (
    .clk(clk), .nrst(nrst), .start_i(start_i), .mode_i(mode_i),
    .base_addr_i(base_addr_i), .num_rows_i(num_rows_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .rd_data_i(rd_data_i), .wc_write_o(wc_write_o), .wc_read_o(wc_read_o),
    .wc_addr_o(wc_addr_o), .wc_wr_data_o(wc_wr_data_o),
    .wc_ready_i(wc_ready_i), .wc_done_i(wc_done_i),
    .busy_o(busy_o), .finish_o(finish_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle counter and stream/finish monitor. Edge numbers are the pre-edge cyc value.
  int cyc = 0;
  int fin_cnt = 0;
  int fin_cyc = 0;
  logic fin_busy = 1'b0;
  int inrdy_cnt = 0;
  int in_idx = 0;
  assign in_data_i = 32'hDA7A0000 | 32'(in_idx);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (finish_o) begin
      fin_cnt  <= fin_cnt + 1;
      fin_cyc  <= cyc;
      fin_busy <= busy_o;
    end
    if (in_ready_o) inrdy_cnt <= inrdy_cnt + 1;
    if (in_valid_i && in_ready_o) in_idx <= in_idx + 1;
  end

  // Controller model: 4-cycle access, ready only when idle and enabled.
  logic          ready_en = 1'b1;
  int            ctl_cnt = 0;
  logic          ctl_rd = 1'b0;
  int            rd_idx = 0;
  logic [NC-1:0] rd_tab [2] = '{32'hDEAD0001, 32'hDEAD0002};
  logic [AW-1:0] q_addr [$];
  logic [NC-1:0] q_data [$];
  logic          q_rd [$];
  int            q_cyc [$];

  assign wc_ready_i = ready_en && (ctl_cnt == 0) && !wc_done_i;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ctl_cnt   <= 0;
      wc_done_i <= 1'b0;
      rd_data_i <= 32'hBAD0BAD0;
    end else begin
      wc_done_i <= 1'b0;
      rd_data_i <= 32'hBAD0BAD0;
      if (wc_write_o || wc_read_o) begin
        check("req_exclusive", wc_write_o & wc_read_o, 1'b0);
        q_addr.push_back(wc_addr_o);
        q_data.push_back(wc_wr_data_o);
        q_rd.push_back(wc_read_o);
        q_cyc.push_back(cyc);
        ctl_rd  <= wc_read_o;
        ctl_cnt <= 3;
      end else if (ctl_cnt != 0) begin
        ctl_cnt <= ctl_cnt - 1;
        if (ctl_cnt == 1) begin
          wc_done_i <= 1'b1;
          if (ctl_rd) begin
            rd_data_i <= rd_tab[rd_idx];
            rd_idx    <= rd_idx + 1;
          end
        end
      end
    end
  end

  task automatic start_blk(input logic m, input int base, input int n, output int t);
    @(negedge clk);
    start_i     = 1'b1;
    mode_i      = m;
    base_addr_i = AW'(base);
    num_rows_i  = (AW+1)'(n);
    t           = cyc;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_fin(input int f0, input string tag);
    int k;
    k = 0;
    while (fin_cnt == f0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(tag, fin_cnt, f0 + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, f0, n0, ir0, h, k;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready_o, 0);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_out_data", out_data_o, 0);
    check("rst_wc_write", wc_write_o, 0);
    check("rst_wc_read", wc_read_o, 0);
    check("rst_wc_addr", wc_addr_o, 0);
    check("rst_wc_wr_data", wc_wr_data_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_finish", finish_o, 0);
    nrst = 1'b1;

    // Write, base 5, 3 rows
    f0 = fin_cnt; n0 = q_addr.size();
    start_blk(1'b0, 5, 3, t);
    check("w3_busy", busy_o, 1);
    wait_fin(f0, "w3_finish");
    repeat (3) @(negedge clk);
    check("w3_fin_once", fin_cnt, f0 + 1);
    check("w3_nreq", q_addr.size(), n0 + 3);
    check("w3_addr0", q_addr[n0], 5);
    check("w3_addr1", q_addr[n0+1], 6);
    check("w3_addr2", q_addr[n0+2], 7);
    check("w3_data0", q_data[n0], 32'hDA7A0000);
    check("w3_data1", q_data[n0+1], 32'hDA7A0001);
    check("w3_data2", q_data[n0+2], 32'hDA7A0002);
    check("w3_kind", q_rd[n0] | q_rd[n0+1] | q_rd[n0+2], 0);
    check("w3_req0_cyc", q_cyc[n0], t + 2);
    check("w3_req1_cyc", q_cyc[n0+1], t + 8);
    check("w3_req2_cyc", q_cyc[n0+2], t + 14);
    check("w3_fin_cyc", fin_cyc, t + 19);
    check("w3_fin_busy", fin_busy, 0);

    // Address wrap
    f0 = fin_cnt; n0 = q_addr.size();
    start_blk(1'b0, 126, 3, t);
    wait_fin(f0, "wrap_finish");
    check("wrap_nreq", q_addr.size(), n0 + 3);
    check("wrap_addr0", q_addr[n0], 126);
    check("wrap_addr1", q_addr[n0+1], 127);
    check("wrap_addr2", q_addr[n0+2], 0);
    check("wrap_data2", q_data[n0+2], 32'hDA7A0005);

    // Zero-row block
    f0 = fin_cnt; n0 = q_addr.size(); ir0 = inrdy_cnt;
    start_blk(1'b0, 9, 0, t);
    check("zero_busy", busy_o, 0);
    wait_fin(f0, "zero_finish");
    repeat (3) @(negedge clk);
    check("zero_fin_cyc", fin_cyc, t + 1);
    check("zero_nreq", q_addr.size(), n0);
    check("zero_in_ready", inrdy_cnt, ir0);

    // Backpressure and start while busy
    f0 = fin_cnt; n0 = q_addr.size();
    ready_en = 1'b0;
    start_blk(1'b0, 20, 1, t);
    @(negedge clk);
    start_i = 1'b1; base_addr_i = 7'd50; num_rows_i = 8'd2;
    @(negedge clk);
    start_i = 1'b0;
    check("bp_no_write", wc_write_o, 0);
    repeat (3) @(negedge clk);
    check("bp_nreq_held", q_addr.size(), n0);
    ready_en = 1'b1;
    wait_fin(f0, "bp_finish");
    repeat (10) @(negedge clk);
    check("bp_nreq", q_addr.size(), n0 + 1);
    check("bp_req_cyc", q_cyc[n0], t + 6);
    check("bp_addr", q_addr[n0], 20);
    check("bp_data", q_data[n0], 32'hDA7A0006);
    check("bp_fin_cyc", fin_cyc, t + 11);
    check("bp_fin_once", fin_cnt, f0 + 1);

    // Reset while waiting on the controller
    f0 = fin_cnt; n0 = q_addr.size();
    start_blk(1'b0, 40, 2, t);
    k = 0;
    while (q_addr.size() == n0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("rw_req_seen", q_addr.size(), n0 + 1);
    nrst = 1'b0;
    #1;
    check("rw_busy", busy_o, 0);
    check("rw_in_ready", in_ready_o, 0);
    check("rw_wc_write", wc_write_o, 0);
    check("rw_wc_read", wc_read_o, 0);
    check("rw_wc_addr", wc_addr_o, 0);
    check("rw_wc_wr_data", wc_wr_data_o, 0);
    check("rw_finish", finish_o, 0);
    check("rw_out_valid", out_valid_o, 0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (5) @(negedge clk);
    check("rw_no_finish", fin_cnt, f0);
    check("rw_no_req", q_addr.size(), n0 + 1);
    f0 = fin_cnt; n0 = q_addr.size();
    start_blk(1'b0, 60, 2, t);
    wait_fin(f0, "rw2_finish");
    check("rw2_nreq", q_addr.size(), n0 + 2);
    check("rw2_addr0", q_addr[n0], 60);
    check("rw2_addr1", q_addr[n0+1], 61);
    check("rw2_data0", q_data[n0], 32'hDA7A0008);
    check("rw2_data1", q_data[n0+1], 32'hDA7A0009);
    check("rw2_fin_cyc", fin_cyc, t + 13);

`ifdef LOADER_READBACK_EN
    // Readback, base 10, 2 rows, output backpressure
    f0 = fin_cnt; n0 = q_addr.size();
    start_blk(1'b1, 10, 2, t);
    k = 0;
    while (!out_valid_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("rb_valid_cyc", cyc, t + 6);
    check("rb_data0", out_data_o, 32'hDEAD0001);
    check("rb_req0_rd", q_rd[n0], 1);
    check("rb_addr0", q_addr[n0], 10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rb_hold_valid", out_valid_o, 1);
      check("rb_hold_data", out_data_o, 32'hDEAD0001);
    end
    check("rb_no_req1", q_addr.size(), n0 + 1);
    out_ready_i = 1'b1;
    h = cyc;
    @(negedge clk);
    out_ready_i = 1'b0;
    k = 0;
    while (!out_valid_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("rb_nreq", q_addr.size(), n0 + 2);
    check("rb_req1_cyc", q_cyc[n0+1], h + 1);
    check("rb_req1_rd", q_rd[n0+1], 1);
    check("rb_addr1", q_addr[n0+1], 11);
    check("rb_data1", out_data_o, 32'hDEAD0002);
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
    wait_fin(f0, "rb_finish");
    check("rb_out_valid_end", out_valid_o, 0);
`else
    // mode_i ignored: readback request behaves as a write
    f0 = fin_cnt; n0 = q_addr.size();
    start_blk(1'b1, 30, 1, t);
    check("nrb_in_ready", in_ready_o, 1);
    wait_fin(f0, "nrb_finish");
    check("nrb_nreq", q_addr.size(), n0 + 1);
    check("nrb_kind", q_rd[n0], 0);
    check("nrb_addr", q_addr[n0], 30);
    check("nrb_data", q_data[n0], 32'hDA7A000A);
    check("nrb_out_valid", out_valid_o, 0);
    check("nrb_out_data", out_data_o, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/c3sram_loader.md
# c3sram_loader

Request-side sequencer for the C3SRAM write/read controller. Accepts a block command (base row, row count, direction), pulls row data from a valid/ready input stream and issues one write request per row, or issues read requests and pushes captured sense-amp data to a valid/ready output stream. Sits between the host/DMA fabric and the array's write/read controller, and owns all request/handshake sequencing toward it.

## Interface
Parameters:
- numRows, 128, array rows; address width AW = $clog2(numRows)
- numCols, 32, array columns = row data width

Ports:
- clk  in  1  clock
- nrst  in  1  reset; asynchronous, active-low
- start_i  in  1  command strobe, sampled only in S_IDLE
- mode_i  in  1  0 = write block, 1 = readback block; sampled with start_i
- base_addr_i  in  AW  first row of block
- num_rows_i  in  AW+1  rows in block, 0..numRows
- in_valid_i / in_ready_o  in/out  1  write-data stream handshake
- in_data_i  in  numCols  write row data
- out_valid_o / out_ready_i  out/in  1  readback stream handshake
- out_data_o  out  numCols  readback row data
- rd_data_i  in  numCols  sense-amp row data from array, valid while wc_done_i is high during a read
- wc_write_o, wc_read_o  out  1  one-cycle request pulses to the controller
- wc_addr_o  out  AW  target row
- wc_wr_data_o  out  numCols  row data for the write
- wc_ready_i  in  1  controller idle
- wc_done_i  in  1  controller completion pulse
- busy_o  out  1  state != S_IDLE
- finish_o  out  1  one-cycle block-complete pulse

## Operation
- States: S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_DRAIN.
- S_IDLE: on start_i, latch mode, addr_q = base_addr_i, remaining_q = num_rows_i. If num_rows_i == 0, stay in S_IDLE and pulse finish_o the next cycle. Otherwise go to S_FETCH (write) or S_ISSUE (read).
- S_FETCH: in_ready_o = 1. On in_valid_i, latch in_data_i into the data register and go to S_ISSUE.
- S_ISSUE: when wc_ready_i = 1, assert wc_write_o or wc_read_o for exactly that cycle, then go to S_WAIT. If wc_ready_i = 0, hold with no request.
- S_WAIT: wait for wc_done_i. On done, decrement remaining_q and increment addr_q modulo numRows (row numRows-1 wraps to 0).
  - Write mode: go to S_FETCH if remaining > 0 after the decrement, else S_IDLE with finish.
  - Read mode: capture rd_data_i into out_data_o and go to S_DRAIN.
- S_DRAIN: out_valid_o = 1 and out_data_o is held stable. On out_ready_i, go to S_ISSUE if rows remain, else S_IDLE with finish.
- wc_addr_o and wc_wr_data_o come from registers and are stable from S_ISSUE through S_WAIT.
- wc_write_o and wc_read_o are never high together.
- wc_done_i outside S_WAIT is ignored.
- start_i while busy is ignored.
- Reset mid-operation: all state cleared and no request issued. The controller's own reset is relied on to abort any in-flight access.

## Timing
- Reset values: in_ready_o 0, out_valid_o 0, out_data_o 0, wc_write_o 0, wc_read_o 0, wc_addr_o 0, wc_wr_data_o 0, busy_o 0, finish_o 0.
- start_i accepted at edge T: busy_o is high from T+1.
- Write row: the request pulse goes out at the earliest 1 cycle after the in handshake. The next in_ready_o is the cycle after wc_done_i.
- Read row: out_valid_o rises the cycle after wc_done_i. The next request is at the earliest the cycle after the out handshake.
- finish_o is registered. It is high for exactly one cycle, the first cycle back in S_IDLE (busy_o already low). A new start_i is accepted in that same cycle.
- With a controller that has a 4-cycle access and ready immediately, one write row takes at least 1 (fetch) + 1 (issue) + 4 (access) cycles.

## Configuration
- LOADER_READBACK_EN defined: readback mode as described above.
- LOADER_READBACK_EN not defined:
  - mode_i is ignored and every block is a write.
  - wc_read_o, out_valid_o and out_data_o are tied to 0.
  - S_DRAIN and the readback register are removed.

## Test plan
- Write, base 5, 3 rows, data A/B/C, in_valid always high: three wc_write_o pulses with addr 5, 6, 7 and data A, B, C; one finish_o after the third done; busy_o low that cycle.
- Wrap: write, base 126, 3 rows (numRows = 128): addresses 126, 127, 0.
- num_rows_i = 0: no request and no in_ready_o; finish_o the cycle after start_i.
- Readback, base 10, 2 rows, rd_data_i = 0xDEAD0001 then 0xDEAD0002, out_ready_i held low for 5 cycles: out_data_o stable with out_valid_o high; the second wc_read_o comes only after the out handshake.
- Backpressure: wc_ready_i low for 4 cycles in S_ISSUE gives no request pulse; exactly one pulse in the first cycle it is high. start_i while busy is ignored.
- nrst asserted in S_WAIT: all outputs 0 immediately; after release, a fresh start_i runs a full block correctly.
